// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy game datapath.
//
// Contents:
//   flap_state_t   2-bit debounce FSM state encoding
//                  (IDLE=0, ARM_PRESS=1, HELD=2, ARM_RELEASE=3)
//   is_pressed()   true for the states in which the debounced button is
//                  considered down (HELD and ARM_RELEASE)
package flappy_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ARM_PRESS   = 2'd1,
        HELD        = 2'd2,
        ARM_RELEASE = 2'd3
    } flap_state_t;

    // ARM_RELEASE still counts as pressed: the button has not yet been
    // confirmed released, so the debounced level must stay high.
    function automatic logic is_pressed(input flap_state_t s);
        return (s == HELD) || (s == ARM_RELEASE);
    endfunction

endpackage

// File: rtl/edge_tick.sv
// Rising-edge tick generator for one bit of the free-running divider count.
//
// Ports:
//   clk     in   system clock
//   clkdiv  in   32-bit free-running divider count (same clock domain)
//   tick    out  high for exactly one cycle after each 0->1 transition of
//                clkdiv[BIT]
//
// The tap register has no reset on purpose: it keeps following the divider
// while the rest of the design is held in reset, so the first cycle after
// reset release never sees a stale 0 in the tap and never fires a false tick.
// Falling edges (including the 32-bit wrap) never produce a tick.
module edge_tick #(
    parameter int BIT = 16
) (
    input  logic        clk,
    input  logic [31:0] clkdiv,
    output logic        tick
);

    logic tap_q;

    // Only one divider bit matters; the rest are folded away here.
    logic [31:0] other_bits;
    logic        unused_other_bits;

    assign other_bits        = clkdiv & ~(32'd1 << BIT);
    assign unused_other_bits = ^other_bits;

    always_ff @(posedge clk) begin
        tap_q <= clkdiv[BIT];
    end

    assign tick = clkdiv[BIT] & ~tap_q;

endmodule

// File: rtl/flap_debounce.sv
// Flap push-button debouncer.
//
// Samples the synchronised button on rising edges of clkdiv[SAMPLE_BIT] and
// only changes the debounced state after STABLE_CNT consecutive agreeing
// samples. Produces a registered debounced level plus one-cycle press and
// release strobes (the strobes are gated by en; the level is not).
//
// Ports:
//   clk            in   system clock
//   rst            in   synchronous active-low reset
//   clkdiv         in   32-bit free-running divider count
//   btn_raw        in   raw asynchronous button, active-high
//   en             in   strobe enable (state tracking ignores it)
//   btn_level      out  debounced button level
//   flap_pulse     out  one-cycle strobe on debounced press
//   release_pulse  out  one-cycle strobe on debounced release
//
// Parameters:
//   SAMPLE_BIT  divider bit whose rising edge is the sample tick
//               (sample period 2^(SAMPLE_BIT+1) clk cycles)
//   STABLE_CNT  consecutive agreeing samples needed, 1..255
module flap_debounce
    import flappy_pkg::*;
#(
    parameter int SAMPLE_BIT = 16,
    parameter int STABLE_CNT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] clkdiv,
    input  logic        btn_raw,
    input  logic        en,
    output logic        btn_level,
    output logic        flap_pulse,
    output logic        release_pulse
);

    localparam int            CW   = $clog2(STABLE_CNT + 1);
    localparam logic [CW-1:0] ONE  = CW'(1);
    // cnt+1 == STABLE_CNT is tested as cnt == STABLE_CNT-1 so no carry bit
    // is needed.
    localparam logic [CW-1:0] LAST = CW'(STABLE_CNT - 1);

    logic        tick;
    logic        btn_p0;
    logic        btn_s;

    flap_state_t   state;
    flap_state_t   state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          press_event;
    logic          release_event;

    edge_tick #(
        .BIT (SAMPLE_BIT)
    ) u_tick (
        .clk    (clk),
        .clkdiv (clkdiv),
        .tick   (tick)
    );

    // ---- stage: two-flop synchroniser for the asynchronous button ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            btn_p0 <= 1'b0;
            btn_s  <= 1'b0;
        end else begin
            btn_p0 <= btn_raw;
            btn_s  <= btn_p0;
        end
    end

    // ---- stage: debounce FSM next-state (moves only on tick cycles) ----
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (tick) begin
            unique case (state)
                IDLE: begin
                    if (btn_s) begin
                        cnt_next   = ONE;
                        state_next = (STABLE_CNT == 1) ? HELD : ARM_PRESS;
                    end
                end
                ARM_PRESS: begin
                    if (!btn_s) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else if (cnt == LAST) begin
                        state_next = HELD;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + ONE;
                    end
                end
                HELD: begin
                    if (!btn_s) begin
                        cnt_next   = ONE;
                        state_next = (STABLE_CNT == 1) ? IDLE : ARM_RELEASE;
                    end
                end
                ARM_RELEASE: begin
                    if (btn_s) begin
                        state_next = HELD;
                        cnt_next   = '0;
                    end else if (cnt == LAST) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + ONE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Strobes fire only on a genuine level change; aborted arming
    // (ARM_RELEASE->HELD, ARM_PRESS->IDLE) crosses no pressed/released
    // boundary and so yields nothing.
    assign press_event   = tick && !is_pressed(state) && (state_next == HELD);
    assign release_event = tick &&  is_pressed(state) && (state_next == IDLE);

    // ---- stage: state register and registered outputs ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            btn_level     <= 1'b0;
            flap_pulse    <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            btn_level     <= is_pressed(state_next);
            flap_pulse    <= press_event & en;
            release_pulse <= release_event & en;
        end
    end

endmodule

// File: tb/tb_flap_debounce.sv
// Directed bench for flap_debounce with SAMPLE_BIT=2 (tick when the value
// presented on clkdiv has low bits 3'b100) and STABLE_CNT=3.
module tb_flap_debounce;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] clkdiv;
    logic        btn_raw;
    logic        en;
    logic        btn_level;
    logic        flap_pulse;
    logic        release_pulse;

    int total   = 0;
    int passed  = 0;
    int flap_n  = 0;
    int rel_n   = 0;

    flap_debounce #(
        .SAMPLE_BIT (2),
        .STABLE_CNT (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clkdiv        (clkdiv),
        .btn_raw       (btn_raw),
        .en            (en),
        .btn_level     (btn_level),
        .flap_pulse    (flap_pulse),
        .release_pulse (release_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One clock edge; inputs change and outputs are sampled 1 time unit
    // after the edge. Pulses seen are tallied.
    task automatic step();
        @(posedge clk);
        #1;
        clkdiv = clkdiv + 32'd1;
        if (flap_pulse === 1'b1)    flap_n++;
        if (release_pulse === 1'b1) rel_n++;
    endtask

    // Advance through the next tick edge; returns just after it.
    task automatic tick_step();
        for (int i = 0; i < 8 && clkdiv[2:0] != 3'd4; i++) step();
        step();
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst     = 1'b0;
        clkdiv  = 32'd0;
        btn_raw = 1'b1;
        en      = 1'b1;

        // Reset with button held and tap high at release.
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 1 || i == 4) begin
                chk("rst_level", btn_level, 0);
                chk("rst_flap", flap_pulse, 0);
                chk("rst_rel", release_pulse, 0);
            end
        end
        rst = 1'b1;
        flap_n = 0;
        rel_n  = 0;
        step();
        chk("post_rst_level", btn_level, 0);
        tick_step();
        tick_step();
        chk("rst_press_2ticks_n", flap_n, 0);
        chk("rst_press_2ticks_level", btn_level, 0);
        tick_step();
        chk("rst_press_pulse", flap_pulse, 1);
        chk("rst_press_level", btn_level, 1);
        step();
        chk("rst_press_pulse_width", flap_pulse, 0);

        // One-tick low glitch while HELD: no release.
        btn_raw = 1'b0;
        tick_step();
        chk("glitch_level_a", btn_level, 1);
        btn_raw = 1'b1;
        tick_step();
        chk("glitch_level_b", btn_level, 1);
        tick_step();
        tick_step();
        chk("glitch_rel_n", rel_n, 0);
        chk("glitch_flap_n", flap_n, 1);

        // Clean release.
        btn_raw = 1'b0;
        tick_step();
        tick_step();
        chk("release_2ticks_level", btn_level, 1);
        tick_step();
        chk("release_pulse", release_pulse, 1);
        chk("release_level", btn_level, 0);
        step();
        chk("release_pulse_width", release_pulse, 0);
        chk("release_n", rel_n, 1);

        // Clean press.
        flap_n = 0;
        btn_raw = 1'b1;
        tick_step();
        tick_step();
        chk("press_2ticks_flap", flap_n, 0);
        tick_step();
        chk("press_pulse", flap_pulse, 1);
        chk("press_level", btn_level, 1);
        step();
        chk("press_pulse_width", flap_pulse, 0);
        tick_step();
        tick_step();
        chk("press_hold_level", btn_level, 1);
        chk("press_flap_n", flap_n, 1);

        // Back to IDLE.
        btn_raw = 1'b0;
        tick_step();
        tick_step();
        tick_step();
        chk("idle_again_level", btn_level, 0);

        // Bounce: 2 high, 1 low, then needs 3 fresh highs.
        flap_n = 0;
        btn_raw = 1'b1;
        tick_step();
        tick_step();
        btn_raw = 1'b0;
        tick_step();
        chk("bounce_low_level", btn_level, 0);
        btn_raw = 1'b1;
        tick_step();
        tick_step();
        chk("bounce_2fresh_flap", flap_n, 0);
        chk("bounce_2fresh_level", btn_level, 0);
        tick_step();
        chk("bounce_pulse", flap_pulse, 1);
        step();
        tick_step();
        chk("bounce_flap_n", flap_n, 1);

        // Release back to IDLE.
        btn_raw = 1'b0;
        tick_step();
        tick_step();
        tick_step();
        chk("bounce_release_level", btn_level, 0);

        // Enable gate: press with en=0, release with en=1 at the release tick.
        flap_n = 0;
        rel_n  = 0;
        en = 1'b0;
        btn_raw = 1'b1;
        tick_step();
        tick_step();
        tick_step();
        chk("gate_level", btn_level, 1);
        chk("gate_flap_pulse", flap_pulse, 0);
        step();
        chk("gate_flap_n", flap_n, 0);
        btn_raw = 1'b0;
        tick_step();
        tick_step();
        en = 1'b1;
        tick_step();
        chk("gate_release_pulse", release_pulse, 1);
        chk("gate_release_level", btn_level, 0);

        // Mid-operation reset during ARM_PRESS.
        flap_n = 0;
        btn_raw = 1'b1;
        tick_step();
        tick_step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("midrst_level", btn_level, 0);
        tick_step();
        chk("midrst_t1_flap", flap_n, 0);
        tick_step();
        chk("midrst_t2_flap", flap_n, 0);
        chk("midrst_t2_level", btn_level, 0);
        tick_step();
        chk("midrst_t3_pulse", flap_pulse, 1);
        chk("midrst_t3_level", btn_level, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
